// File: rtl/param_stack.sv
`default_nettype none
// ============================================================================
// Module   : param_stack
// Purpose  : Parametrised operand/operator stack for the expression
//            calculator. It holds up to 2^DEPTH_LOG2 words of DATA_WIDTH bits.
//            Each of the following ops completes in one cycle: push, pop,
//            pop-two, replace-top (push+pop) and reduce (push+pop2).
//            Illegal ops are rejected and leave the state unchanged.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  entry width in bits (default 32)
//   DEPTH_LOG2  log2 of capacity, CAP = 2^DEPTH_LOG2 (default 6)
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset, highest priority
//   flush       empty the stack (overrides push/pop/pop2)
//   push        push i_data (combines with pop / pop2)
//   pop         remove top entry
//   pop2        remove top two entries (overrides pop)
//   i_data      write data
//   o_data      top entry, 0 when empty
//   o_data2     entry below top, 0 when count < 2
//   count       number of valid entries, 0..CAP
//   empty       count == 0
//   full        count == CAP
//   err         one-cycle pulse after an illegal op is rejected
//   err_sticky  set by err, cleared by rst or flush
// Configuration
//   STACK_ERR_EN  when defined, err/err_sticky are generated; otherwise they
//                 are tied to 0. Illegal ops are rejected in both builds.
// ============================================================================
module param_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  pop2,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [DATA_WIDTH-1:0] o_data2,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  err,
  output logic                  err_sticky
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int CAP   = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0]      C_CNT_CAP = CNT_W'(CAP);
  localparam logic [CNT_W-1:0]      C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]      C_CNT_TWO = CNT_W'(2);
  localparam logic [DEPTH_LOG2-1:0] C_IDX_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] C_IDX_TWO = DEPTH_LOG2'(2);

  // Storage and occupancy
  logic [DATA_WIDTH-1:0] mem [CAP];
  logic [CNT_W-1:0]      count_r;

  // Index arithmetic is modulo CAP. When the stack is full the low bits of
  // count are zero, and subtracting from zero still lands on the correct
  // top/below slots.
  logic [DEPTH_LOG2-1:0] push_idx;
  logic [DEPTH_LOG2-1:0] top_idx;
  logic [DEPTH_LOG2-1:0] below_idx;

  assign push_idx  = count_r[DEPTH_LOG2-1:0];
  assign top_idx   = push_idx - C_IDX_ONE;
  assign below_idx = push_idx - C_IDX_TWO;

  logic has_one;
  logic has_two;
  logic is_full;

  assign has_one = (count_r >= C_CNT_ONE);
  assign has_two = (count_r >= C_CNT_TWO);
  assign is_full = (count_r == C_CNT_CAP);

  // Op decode in strict priority order
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [CNT_W-1:0]      next_count;
  logic                  illegal;

  always_comb begin
    wr_en      = 1'b0;
    wr_idx     = push_idx;
    next_count = count_r;
    illegal    = 1'b0;

    if (flush) begin
      next_count = '0;
    end else if (push && pop2) begin
      // REDUCE: the result overwrites the lower of the two operands
      if (has_two) begin
        wr_en      = 1'b1;
        wr_idx     = below_idx;
        next_count = count_r - C_CNT_ONE;
      end else begin
        illegal = 1'b1;
      end
    end else if (push && pop) begin
      // REPLACE: overwrite the top in place
      if (has_one) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        illegal = 1'b1;
      end
    end else if (push) begin
      if (!is_full) begin
        wr_en      = 1'b1;
        wr_idx     = push_idx;
        next_count = count_r + C_CNT_ONE;
      end else begin
        illegal = 1'b1;
      end
    end else if (pop2) begin
      if (has_two) begin
        next_count = count_r - C_CNT_TWO;
      end else begin
        illegal = 1'b1;
      end
    end else if (pop) begin
      if (has_one) begin
        next_count = count_r - C_CNT_ONE;
      end else begin
        illegal = 1'b1;
      end
    end
  end

  // Occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      count_r <= next_count;
    end
  end

  // Storage is not reset. Popped words are left in place because the
  // outputs mask them through count. Writes are suppressed during rst so
  // that an op in flight cannot disturb memory.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= i_data;
    end
  end

`ifdef STACK_ERR_EN
  logic err_r;
  logic err_sticky_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      err_r <= illegal;
      // flush is never illegal, so clearing here cannot hide a new error
      if (flush) begin
        err_sticky_r <= 1'b0;
      end else if (illegal) begin
        err_sticky_r <= 1'b1;
      end
    end
  end

  assign err        = err_r;
  assign err_sticky = err_sticky_r;
`else
  // Rejection still happens in the decode; only the reporting is removed
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign err            = 1'b0;
  assign err_sticky     = 1'b0;
`endif

  // Outputs, combinational from count and mem
  assign count   = count_r;
  assign empty   = !has_one;
  assign full    = is_full;
  assign o_data  = has_one ? mem[top_idx]   : '0;
  assign o_data2 = has_two ? mem[below_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_param_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_stack
// Purpose  : Self-checking bench for param_stack (DATA_WIDTH=32, CAP=4).
//            It runs directed scenarios and then randomized op sequences.
//            Every result is compared against a queue-based reference
//            model of the stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_stack;

  localparam int DW  = 32;
  localparam int DL2 = 2;
  localparam int CAP = 1 << DL2;

`ifdef STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          push;
  logic          pop;
  logic          pop2;
  logic [DW-1:0] i_data;
  logic [DW-1:0] o_data;
  logic [DW-1:0] o_data2;
  logic [DL2:0]  count;
  logic          empty;
  logic          full;
  logic          err;
  logic          err_sticky;

  param_stack #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
    .pop2(pop2), .i_data(i_data), .o_data(o_data), .o_data2(o_data2),
    .count(count), .empty(empty), .full(full), .err(err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: a plain queue with the top of stack at the back
  logic [DW-1:0] q[$];
  bit            m_err;
  bit            m_sticky;

  function automatic logic [DW-1:0] m_top();
    return (q.size() >= 1) ? q[q.size()-1] : '0;
  endfunction

  function automatic logic [DW-1:0] m_below();
    return (q.size() >= 2) ? q[q.size()-2] : '0;
  endfunction

  // Apply one op to the model, following the decode priority order
  task automatic model_op(input bit f, input bit p, input bit po,
                          input bit po2, input logic [DW-1:0] d);
    bit legal;
    legal = 1'b1;
    if (f) begin
      q.delete();
    end else if (p && po2) begin
      if (q.size() >= 2) begin
        void'(q.pop_back()); void'(q.pop_back()); q.push_back(d);
      end else legal = 1'b0;
    end else if (p && po) begin
      if (q.size() >= 1) begin
        void'(q.pop_back()); q.push_back(d);
      end else legal = 1'b0;
    end else if (p) begin
      if (q.size() < CAP) q.push_back(d);
      else legal = 1'b0;
    end else if (po2) begin
      if (q.size() >= 2) begin
        void'(q.pop_back()); void'(q.pop_back());
      end else legal = 1'b0;
    end else if (po) begin
      if (q.size() >= 1) void'(q.pop_back());
      else legal = 1'b0;
    end
    m_err = ERR_EN && !legal;
    if (f) m_sticky = 1'b0;
    else if (m_err) m_sticky = 1'b1;
  endtask

  // Drive one op for a single clock. The op is driven on the falling edge
  // and the outputs are valid 1 time unit after the rising edge.
  task automatic do_op(input bit f, input bit p, input bit po, input bit po2,
                       input logic [DW-1:0] d);
    @(negedge clk);
    flush = f; push = p; pop = po; pop2 = po2; i_data = d;
    @(posedge clk);
    model_op(f, p, po, po2, d);
    #1;
    flush = 0; push = 0; pop = 0; pop2 = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; flush = 0; push = 0; pop = 0; pop2 = 0; i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    q.delete(); m_err = 0; m_sticky = 0;
    checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); else passed++;
    checks++; if (o_data !== '0 || o_data2 !== '0) $display("FAIL reset_data: got %0h/%0h want 0/0", o_data, o_data2); else passed++;
    checks++; if (err !== 1'b0 || err_sticky !== 1'b0) $display("FAIL reset_err: got %b/%b want 0/0", err, err_sticky); else passed++;
  endtask

  task automatic test_push();
    do_op(0, 1, 0, 0, 32'd5);
    do_op(0, 1, 0, 0, 32'd7);
    checks++; if (count !== 3'd2 || empty !== 1'b0) $display("FAIL push_count: got %0d empty=%b want 2/0", count, empty); else passed++;
    checks++; if (o_data !== 32'd7 || o_data2 !== 32'd5) $display("FAIL push_data: got %0d/%0d want 7/5", o_data, o_data2); else passed++;
  endtask

  task automatic test_reduce_replace();
    do_op(0, 1, 0, 1, 32'd12);
    checks++; if (count !== 3'd1 || o_data !== 32'd12 || o_data2 !== '0) $display("FAIL reduce: got cnt=%0d top=%0d below=%0d want 1/12/0", count, o_data, o_data2); else passed++;
    do_op(0, 1, 1, 0, 32'd3);
    checks++; if (count !== 3'd1 || o_data !== 32'd3) $display("FAIL replace: got cnt=%0d top=%0d want 1/3", count, o_data); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL replace_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_full();
    do_op(1, 0, 0, 0, '0);
    for (int i = 1; i <= 4; i++) do_op(0, 1, 0, 0, DW'(i));
    checks++; if (full !== 1'b1 || count !== 3'd4) $display("FAIL full_set: got full=%b cnt=%0d want 1/4", full, count); else passed++;
    do_op(0, 1, 0, 0, 32'd9);
    checks++; if (err !== ERR_EN || err_sticky !== ERR_EN) $display("FAIL overflow_err: got %b/%b want %b/%b", err, err_sticky, ERR_EN, ERR_EN); else passed++;
    checks++; if (count !== 3'd4 || o_data !== 32'd4 || o_data2 !== 32'd3) $display("FAIL overflow_hold: got cnt=%0d top=%0d below=%0d want 4/4/3", count, o_data, o_data2); else passed++;
    do_op(0, 0, 0, 0, '0);
    checks++; if (err !== 1'b0 || err_sticky !== ERR_EN) $display("FAIL err_pulse: got %b/%b want 0/%b", err, err_sticky, ERR_EN); else passed++;
    // REDUCE is still legal when full
    do_op(0, 1, 0, 1, 32'd77);
    checks++; if (count !== 3'd3 || o_data !== 32'd77 || o_data2 !== 32'd2 || err !== 1'b0) $display("FAIL reduce_full: got cnt=%0d top=%0d below=%0d err=%b want 3/77/2/0", count, o_data, o_data2, err); else passed++;
  endtask

  task automatic test_underflow();
    do_op(1, 0, 0, 0, '0);
    do_op(0, 0, 1, 0, '0);
    checks++; if (err !== ERR_EN || count !== 3'd0) $display("FAIL pop_empty: got err=%b cnt=%0d want %b/0", err, count, ERR_EN); else passed++;
    do_op(0, 1, 0, 0, 32'd6);
    do_op(0, 0, 0, 1, '0);
    checks++; if (err !== ERR_EN || count !== 3'd1 || o_data !== 32'd6) $display("FAIL pop2_one: got err=%b cnt=%0d top=%0d want %b/1/6", err, count, o_data, ERR_EN); else passed++;
  endtask

  task automatic test_flush();
    do_op(1, 0, 0, 0, '0);
    do_op(0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) do_op(0, 1, 0, 0, DW'(20 + i));
    checks++; if (count !== 3'd3 || err_sticky !== ERR_EN) $display("FAIL flush_pre: got cnt=%0d sticky=%b want 3/%b", count, err_sticky, ERR_EN); else passed++;
    do_op(1, 1, 0, 0, 32'd8);
    checks++; if (count !== 3'd0 || empty !== 1'b1 || o_data !== '0 || err_sticky !== 1'b0) $display("FAIL flush_push: got cnt=%0d empty=%b top=%0d sticky=%b want 0/1/0/0", count, empty, o_data, err_sticky); else passed++;
  endtask

  task automatic test_rst_mid();
    do_op(0, 1, 0, 0, 32'd40);
    do_op(0, 1, 0, 0, 32'd41);
    do_op(0, 0, 0, 1, '0);
    do_op(0, 0, 0, 1, '0);
    do_op(0, 1, 0, 0, 32'd42);
    do_op(0, 1, 0, 0, 32'd43);
    @(negedge clk);
    rst = 1; push = 1; i_data = 32'd44;
    @(posedge clk);
    #1;
    rst = 0; push = 0;
    q.delete(); m_err = 0; m_sticky = 0;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || o_data !== '0 || o_data2 !== '0 || err !== 1'b0 || err_sticky !== 1'b0)
      $display("FAIL rst_mid: got cnt=%0d empty=%b full=%b top=%0d below=%0d err=%b sticky=%b want reset values", count, empty, full, o_data, o_data2, err, err_sticky);
    else passed++;
  endtask

  task automatic test_random();
    bit f, p, po, po2;
    logic [DW-1:0] d;
    for (int n = 0; n < 400; n++) begin
      f   = ($urandom_range(0, 24) == 0);
      p   = $urandom_range(0, 1);
      po  = ($urandom_range(0, 2) == 0);
      po2 = ($urandom_range(0, 3) == 0);
      d   = $urandom;
      do_op(f, p, po, po2, d);
      checks++;
      if (count !== ($bits(count))'(q.size()) || o_data !== m_top() || o_data2 !== m_below() ||
          empty !== (q.size() == 0) || full !== (q.size() == CAP) ||
          err !== m_err || err_sticky !== m_sticky)
        $display("FAIL random_step%0d: got cnt=%0d top=%0h below=%0h e=%b f=%b err=%b st=%b want cnt=%0d top=%0h below=%0h err=%b st=%b",
                 n, count, o_data, o_data2, empty, full, err, err_sticky,
                 q.size(), m_top(), m_below(), m_err, m_sticky);
      else passed++;
    end
  endtask

  initial begin
    rst = 1; flush = 0; push = 0; pop = 0; pop2 = 0; i_data = '0;
    test_reset();
    test_push();
    test_reduce_replace();
    test_full();
    test_underflow();
    test_flush();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
